// File: rtl/seq_alu_ctrl.sv
// ---------------------------------------------------------------------------
// seq_alu_ctrl
//
// Iteration sequencer for the sequential multiply/divide datapath. On an
// accepted start it issues a one-cycle operand load, then ITERATIONS step
// cycles. A divide adds one remainder fix-up cycle. Completion is reported
// with a one-cycle done pulse and a level ready flag. Everything is clocked
// on the rising edge of clk with a synchronous active-high reset.
//
// Optional feature macro: SEQ_ALU_CTRL_EARLY_EXIT_EN
//   When defined, a multiply finishes early: a RUN step taken while
//   rest_zero=1 becomes the final step, and step_idx freezes there so the
//   datapath can apply the remaining shift in one go. Divides are unaffected.
//   When undefined, rest_zero is ignored.
//
// Parameters
//   ITERATIONS  step cycles per operation (>= 2)
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   request a new operation (accepted only when idle)
//   mode       in   0 = multiply, 1 = divide; sampled with start
//   stall      in   hold RUN/FIXUP without issuing a step/fixup
//   abort      in   cancel the current operation, clear ready
//   rest_zero  in   remaining multiplier bits are zero (early exit only)
//   busy       out  operation in progress (LOAD, RUN, FIXUP, DONE)
//   load       out  one-cycle operand-load strobe
//   step       out  iteration enable (combinational)
//   step_idx   out  current step index, 0..ITERATIONS-1
//   last_step  out  high with the final RUN step (combinational)
//   fixup      out  divide remainder-correction strobe (combinational)
//   mode_q     out  latched mode
//   done       out  one-cycle completion pulse
//   ready      out  result valid, level
// ---------------------------------------------------------------------------
module seq_alu_ctrl #(
  parameter int ITERATIONS = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          mode,
  input  logic                          stall,
  input  logic                          abort,
  input  logic                          rest_zero,
  output logic                          busy,
  output logic                          load,
  output logic                          step,
  output logic [$clog2(ITERATIONS)-1:0] step_idx,
  output logic                          last_step,
  output logic                          fixup,
  output logic                          mode_q,
  output logic                          done,
  output logic                          ready
);

  localparam int CW = $clog2(ITERATIONS);
  localparam logic [CW-1:0] LAST_IDX = CW'(ITERATIONS - 1);
  localparam logic [CW-1:0] IDX_ONE  = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_FIXUP,
    ST_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] step_idx_reg, step_idx_next;
  logic          mode_q_reg, mode_q_next;
  logic          ready_reg, ready_next;
  logic          busy_reg, load_reg, done_reg;

  logic run_step;
  logic at_last;
  logic early_exit;
  logic final_step;

  // A step is issued in every unstalled RUN cycle.
  assign run_step = (state_reg == ST_RUN) && !stall;
  assign at_last  = (step_idx_reg == LAST_IDX);

`ifdef SEQ_ALU_CTRL_EARLY_EXIT_EN
  // Only multiplies can stop early; a divide always needs every step.
  assign early_exit = run_step && !mode_q_reg && rest_zero;
`else
  logic unused_rest_zero;
  assign early_exit       = 1'b0;
  assign unused_rest_zero = rest_zero;
`endif

  assign final_step = run_step && (at_last || early_exit);

  // Datapath strobes are combinational so a stall suppresses them in the
  // same cycle.
  assign step      = run_step;
  assign last_step = final_step;
  assign fixup     = (state_reg == ST_FIXUP) && !stall;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    step_idx_next = step_idx_reg;
    mode_q_next   = mode_q_reg;
    ready_next    = ready_reg;

    if (abort) begin
      // Abort beats any normal transition. In IDLE it only drops ready, so a
      // completed result's final index stays visible.
      state_next = ST_IDLE;
      ready_next = 1'b0;
      if (state_reg != ST_IDLE) begin
        step_idx_next = '0;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_next    = ST_LOAD;
            mode_q_next   = mode;
            ready_next    = 1'b0;
            step_idx_next = '0;
          end
        end

        ST_LOAD: begin
          state_next = ST_RUN;
        end

        ST_RUN: begin
          if (final_step) begin
            // The index is left where it is: it saturates at LAST_IDX on a
            // full run and freezes at the exit point on an early exit.
            if (mode_q_reg) begin
              state_next = ST_FIXUP;
            end else begin
              state_next = ST_DONE;
              ready_next = 1'b1;
            end
          end else if (run_step) begin
            step_idx_next = step_idx_reg + IDX_ONE;
          end
        end

        ST_FIXUP: begin
          if (!stall) begin
            state_next = ST_DONE;
            ready_next = 1'b1;
          end
        end

        ST_DONE: begin
          state_next = ST_IDLE;
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State and registered outputs. busy/load/done are registered decodes of
  // the next state so they line up exactly with the state they describe.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      step_idx_reg <= '0;
      mode_q_reg   <= 1'b0;
      ready_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      load_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      step_idx_reg <= step_idx_next;
      mode_q_reg   <= mode_q_next;
      ready_reg    <= ready_next;
      busy_reg     <= (state_next != ST_IDLE);
      load_reg     <= (state_next == ST_LOAD);
      done_reg     <= (state_next == ST_DONE);
    end
  end

  assign busy     = busy_reg;
  assign load     = load_reg;
  assign done     = done_reg;
  assign ready    = ready_reg;
  assign mode_q   = mode_q_reg;
  assign step_idx = step_idx_reg;

endmodule
